mul_seq: RTL and testbench

Iterative radix-2 shift-add multiplier for the multiplier unit. It accepts two SIZE-bit operands on a start pulse and runs SIZE add/shift iterations. It then applies sign correction, fractional alignment and saturation, and presents the 2*SIZE-bit product (mul32_product) to the downstream rounding stage. It trades latency for area against a single-cycle array multiplier.

---
 rtl/mul_pkg.sv | 18 +
 rtl/mul_seq_fix.sv | 32 +++
 rtl/mul_seq.sv | 135 +++++++++++++
 tb/tb_mul_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the sequential multiplier and its consumers.
//   - mul_state_e : controller state encoding (IDLE/RUN/FIX)
//   - MUL_SIZE    : default operand width
//   - MUL_SAT     : fractional-mode saturation value for the default width,
//                   shared with the rounding stage's checkers
package mul_pkg;

    localparam int MUL_SIZE = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mul_state_e;

    localparam logic [2*MUL_SIZE-1:0] MUL_SAT = {1'b0, {(2*MUL_SIZE-1){1'b1}}};

endpackage

// File: rtl/mul_seq_fix.sv
// mul_seq_fix: combinational result fix-up applied once the shift-add loop
// has produced the unsigned magnitude product.
// Ports:
//   acc      in  2*SIZE  unsigned magnitude product
//   res_neg  in  1       result must be negated
//   ibf      in  1       fractional format: left-align by one bit
//   sat      in  1       the single fractional overflow case (-1.0 * -1.0)
//   r        out 2*SIZE  corrected product
module mul_seq_fix #(
    parameter int SIZE = 16
) (
    input  logic [2*SIZE-1:0] acc,
    input  logic              res_neg,
    input  logic              ibf,
    input  logic              sat,
    output logic [2*SIZE-1:0] r
);

    localparam logic [2*SIZE-1:0] SAT_VAL = {1'b0, {(2*SIZE-1){1'b1}}};

    // NOTE: r gets a full assignment first so every path defines it and no latch is inferred.
    always_comb begin
        r = res_neg ? -acc : acc;
        if (ibf) begin
            r = {r[2*SIZE-2:0], 1'b0};
        end
        if (sat) begin
            r = SAT_VAL;
        end
    end

endmodule

// File: rtl/mul_seq.sv
// mul_seq: iterative radix-2 shift-add multiplier. Operands are latched as
// magnitudes on a start pulse in IDLE, SIZE add/shift iterations run in RUN,
// and one FIX cycle applies sign, fractional alignment and saturation.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ps_mul_start       start request (sampled only in IDLE)
//   ps_mul_xSgn/ySgn   operand is two's complement
//   ps_mul_IbF         fractional format
//   op_x, op_y         multiplicand, multiplier (SIZE bits)
//   mul_busy           operation in flight (registered)
//   mul_done           one-cycle completion pulse (registered)
//   mul32_product      2*SIZE product, held until the next completion
module mul_seq
    import mul_pkg::*;
#(
    parameter int SIZE = MUL_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ps_mul_start,
    input  logic              ps_mul_xSgn,
    input  logic              ps_mul_ySgn,
    input  logic              ps_mul_IbF,
    input  logic [SIZE-1:0]   op_x,
    input  logic [SIZE-1:0]   op_y,
    output logic              mul_busy,
    output logic              mul_done,
    output logic [2*SIZE-1:0] mul32_product
);

    localparam int              CW   = $clog2(SIZE + 1);
    localparam logic [CW-1:0]   LAST = CW'(SIZE - 1);
    localparam logic [SIZE-1:0] MIN_NEG = {1'b1, {(SIZE-1){1'b0}}};

    mul_state_e        state, next_state;
    logic [CW-1:0]     cnt;
    logic [2*SIZE-1:0] acc;
    logic [2*SIZE-1:0] mcand;
    logic [SIZE-1:0]   mplier;
    logic              res_neg, ibf, sat;
    logic              load, step, fix;
    logic [SIZE-1:0]   x_mag, y_mag;
    logic              x_neg, y_neg;
    logic [2*SIZE-1:0] fixed;

    // Magnitudes fit SIZE unsigned bits; the most negative value maps to itself.
    assign x_neg = ps_mul_xSgn & op_x[SIZE-1];
    assign y_neg = ps_mul_ySgn & op_y[SIZE-1];
    assign x_mag = x_neg ? -op_x : op_x;
    assign y_mag = y_neg ? -op_y : op_y;

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ps_mul_start) begin
                    load       = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    next_state = ST_FIX;
                end
            end
            ST_FIX: begin
                fix        = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mul_busy <= 1'b0;
            mul_done <= 1'b0;
        end else begin
            state    <= next_state;
            mul_busy <= (next_state != ST_IDLE);
            mul_done <= fix;
        end
    end

    // NOTE: the whole datapath is reset so an aborted operation leaves no stale operand or product behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            res_neg       <= 1'b0;
            ibf           <= 1'b0;
            sat           <= 1'b0;
            mul32_product <= '0;
        end else begin
            if (load) begin
                cnt     <= '0;
                acc     <= '0;
                mcand   <= {{SIZE{1'b0}}, x_mag};
                mplier  <= y_mag;
                res_neg <= x_neg ^ y_neg;
                ibf     <= ps_mul_IbF;
                sat     <= ps_mul_IbF & ps_mul_xSgn & ps_mul_ySgn &
                           (op_x == MIN_NEG) & (op_y == MIN_NEG);
            end
            if (step) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= {mcand[2*SIZE-2:0], 1'b0};
                mplier <= {1'b0, mplier[SIZE-1:1]};
                cnt    <= cnt + 1'b1;
            end
            if (fix) begin
                mul32_product <= fixed;
            end
        end
    end

    mul_seq_fix #(.SIZE(SIZE)) u_fix (
        .acc     (acc),
        .res_neg (res_neg),
        .ibf     (ibf),
        .sat     (sat),
        .r       (fixed)
    );

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed self-checking bench for mul_seq (SIZE=16).
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps_mul_start = 1'b0;
    logic        ps_mul_xSgn = 1'b0;
    logic        ps_mul_ySgn = 1'b0;
    logic        ps_mul_IbF = 1'b0;
    logic [15:0] op_x = '0;
    logic [15:0] op_y = '0;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul32_product;

    int n_cmp = 0;
    int n_err = 0;

    mul_seq #(.SIZE(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ps_mul_start  (ps_mul_start),
        .ps_mul_xSgn   (ps_mul_xSgn),
        .ps_mul_ySgn   (ps_mul_ySgn),
        .ps_mul_IbF    (ps_mul_IbF),
        .op_x          (op_x),
        .op_y          (op_y),
        .mul_busy      (mul_busy),
        .mul_done      (mul_done),
        .mul32_product (mul32_product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: present a start with operands, return at the negedge after E0.
    task automatic launch(input logic [15:0] x, input logic [15:0] y,
                          input logic xs, input logic ys, input logic ibf);
        op_x = x; op_y = y;
        ps_mul_xSgn = xs; ps_mul_ySgn = ys; ps_mul_IbF = ibf;
        ps_mul_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ps_mul_start = 1'b0;
    endtask

    // Count clocks from E0 until mul_done is seen; busy must stay high until then, low at done.
    task automatic wait_done(output int lat, output int busy_bad);
        lat = -1;
        busy_bad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mul_done) begin
                lat = i;
                if (mul_busy) busy_bad++;
                break;
            end else if (!mul_busy) begin
                busy_bad++;
            end
        end
    endtask

    task automatic run_vec(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic xs, input logic ys, input logic ibf,
                           input logic [31:0] exp);
        int lat, bb;
        launch(x, y, xs, ys, ibf);
        wait_done(lat, bb);
        check({tag, "_lat"}, lat, 17);
        check({tag, "_busy"}, bb, 0);
        check(tag, mul32_product, exp);
    endtask

    initial begin
        int lat, bb, dones;

        // Reset state
        #1;
        check("rst_busy", mul_busy, 0);
        check("rst_done", mul_done, 0);
        check("rst_prod", mul32_product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned max, plus one-cycle done and product hold
        run_vec("uns_ffff", 16'hFFFF, 16'hFFFF, 0, 0, 0, 32'hFFFE0001);
        @(negedge clk);
        check("done_1cyc", mul_done, 0);
        check("prod_hold", mul32_product, 32'hFFFE0001);
        check("idle_busy", mul_busy, 0);

        run_vec("sgn_m3x5",  16'hFFFD, 16'h0005, 1, 1, 0, 32'hFFFFFFF1);
        run_vec("frac_half", 16'h4000, 16'h4000, 1, 1, 1, 32'h20000000);
        run_vec("frac_neg",  16'hC000, 16'h4000, 1, 1, 1, 32'hE0000000);
        run_vec("frac_sat",  16'h8000, 16'h8000, 1, 1, 1, 32'h7FFFFFFF);
        run_vec("int_min2",  16'h8000, 16'h8000, 1, 1, 0, 32'h40000000);
        run_vec("zero",      16'h0000, 16'h1234, 0, 0, 0, 32'h00000000);
        run_vec("m1xm1",     16'hFFFF, 16'hFFFF, 1, 1, 0, 32'h00000001);
        run_vec("mixed",     16'hFFFF, 16'hFFFF, 1, 0, 0, 32'hFFFF0001);
        run_vec("uns_min2",  16'h8000, 16'h0002, 0, 0, 0, 32'h00010000);

        // Start held high during RUN with different operands: ignored
        @(negedge clk);
        op_x = 16'h0003; op_y = 16'h0007;
        ps_mul_xSgn = 0; ps_mul_ySgn = 0; ps_mul_IbF = 0;
        ps_mul_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_x = 16'h0100; op_y = 16'h0100; ps_mul_IbF = 1;
        wait_done(lat, bb);
        ps_mul_start = 1'b0;
        check("hold_lat", lat, 17);
        check("hold_prod", mul32_product, 32'h00000015);
        @(posedge clk);
        @(negedge clk);
        check("hold_norelatch", mul_busy, 0);

        // Start in the done cycle is accepted
        @(negedge clk);
        launch(16'h0010, 16'h0011, 0, 0, 0);
        wait_done(lat, bb);
        check("b2b_a", mul32_product, 32'h00000110);
        launch(16'hFFFE, 16'h0003, 1, 0, 0);
        wait_done(lat, bb);
        check("b2b_lat", lat, 17);
        check("b2b_b", mul32_product, 32'hFFFFFFFA);

        // Asynchronous reset at iteration 8
        @(negedge clk);
        launch(16'h1234, 16'h0002, 0, 0, 0);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", mul_busy, 0);
        check("arst_done", mul_done, 0);
        check("arst_prod", mul32_product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (mul_done || mul_busy) dones++;
        end
        check("arst_nodone", dones, 0);
        run_vec("post_rst", 16'h1234, 16'h0002, 0, 0, 0, 32'h00002468);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
